// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, one operation in flight: IDLE -> EXEC -> RESP.
// Operands are registered before they reach the ALU, and the ALU result is
// registered into a response that is held until the consumer takes it.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req0_ctrl,
    input  logic [2:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic grant_any;
    logic grant_id;

    // Arbitration: a lone valid wins; on contention the requester not granted last wins.
    always_comb begin
        grant_any = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any &&  grant_id;

    // Next-state and datapath capture for the three-phase operation.
    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a signal unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    srca_d  = grant_id ? req1_srca : req0_srca;
                    srcb_d  = grant_id ? req1_srcb : req0_srcb;
                    ctrl_d  = grant_id ? req1_ctrl : req0_ctrl;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-operation drops it silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the operand and response registers are reset too, because their
            // values are visible on alu_* and rsp_* right after reset.
            state_q      <= IDLE;
            srca_q       <= '0;
            srcb_q       <= '0;
            ctrl_q       <= '0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            last_q       <= last_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_srca   = srca_q;
    assign alu_srcb   = srcb_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a reference ALU closes the loop, a transaction-level
// model predicts every output each cycle, and directed scenarios pin literal values.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [2:0]   req0_ctrl, req1_ctrl;
    logic [W-1:0] alu_srca, alu_srcb;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_id1    = 0;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_srca  (req0_srca),
        .req0_srcb  (req0_srcb),
        .req1_srca  (req1_srca),
        .req1_srcb  (req1_srcb),
        .req0_ctrl  (req0_ctrl),
        .req1_ctrl  (req1_ctrl),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: and, or, add, sub, slt, sll (srcb << srca); other codes give 0.
    function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b100:  return b << a[4:0];
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_srca, alu_srcb);
    assign alu_zero   = (alu_result == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin winner: lone valid wins, contention goes to the one not served last.
    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return 1 - last;
        return v1 ? 1 : 0;
    endfunction

    // Transaction model: one operation at a time, its age counts edges since acceptance.
    bit           m_ok = 1'b0;
    bit           m_busy;
    int           m_age;
    int           m_last;
    logic [W-1:0] m_a, m_b;
    logic [2:0]   m_c;
    logic         m_id;
    logic [W-1:0] m_res;
    logic         m_zero;
    logic         m_rid;

    always @(posedge clk) begin
        if (reset) begin
            m_ok   <= 1'b1;
            m_busy <= 1'b0;
            m_age  <= 0;
            m_last <= 1;
            m_a    <= '0;
            m_b    <= '0;
            m_c    <= '0;
            m_id   <= 1'b0;
            m_res  <= '0;
            m_zero <= 1'b0;
            m_rid  <= 1'b0;
        end else if (m_ok) begin
            if (!m_busy) begin
                if (req0_valid || req1_valid) begin
                    m_a    <= (pick(req0_valid, req1_valid, m_last) == 1) ? req1_srca : req0_srca;
                    m_b    <= (pick(req0_valid, req1_valid, m_last) == 1) ? req1_srcb : req0_srcb;
                    m_c    <= (pick(req0_valid, req1_valid, m_last) == 1) ? req1_ctrl : req0_ctrl;
                    m_id   <= (pick(req0_valid, req1_valid, m_last) == 1);
                    m_last <= pick(req0_valid, req1_valid, m_last);
                    m_busy <= 1'b1;
                    m_age  <= 1;
                end
            end else if (m_age == 1) begin
                m_res  <= alu_fn(m_c, m_a, m_b);
                m_zero <= (alu_fn(m_c, m_a, m_b) == '0);
                m_rid  <= m_id;
                m_age  <= 2;
            end else if (rsp_ready) begin
                m_busy <= 1'b0;
                m_age  <= 0;
            end
        end
    end

    // Handshake log taken from the DUT's own response port.
    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            n_hs <= n_hs + 1;
            if (rsp_id) n_id1 <= n_id1 + 1;
        end
    end

    // Per-cycle comparison of every output against the model, away from the clock edge.
    always @(negedge clk) begin
        if (m_ok) begin
            check("req0_ready", 64'(req0_ready),
                  64'(!reset && !m_busy && (req0_valid || req1_valid) && pick(req0_valid, req1_valid, m_last) == 0));
            check("req1_ready", 64'(req1_ready),
                  64'(!reset && !m_busy && (req0_valid || req1_valid) && pick(req0_valid, req1_valid, m_last) == 1));
            check("rsp_valid",  64'(rsp_valid),  64'(m_busy && m_age == 2));
            check("rsp_result", 64'(rsp_result), 64'(m_res));
            check("rsp_zero",   64'(rsp_zero),   64'(m_zero));
            check("rsp_id",     64'(rsp_id),     64'(m_rid));
            check("alu_srca",   64'(alu_srca),   64'(m_a));
            check("alu_srcb",   64'(alu_srcb),   64'(m_b));
            check("alu_ctrl",   64'(alu_ctrl),   64'(m_c));
        end
    end

    task automatic idle_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        if (n == 0) begin
            req0_valid = 1'b1; req0_srca = a; req0_srcb = b; req0_ctrl = c;
        end else begin
            req1_valid = 1'b1; req1_srca = a; req1_srcb = b; req1_ctrl = c;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Wait for rsp_valid at negedges; lat counts negedges seen, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 16);
        if (!rsp_valid) check("rsp_valid_timeout", 64'(rsp_valid), 64'(1));
    endtask

    // One request from IDLE with rsp_ready high, checking grant, ALU drive, latency and response.
    task automatic run_op(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c,
                          input logic [W-1:0] er, input logic ez, input string nm);
        rsp_ready = 1'b1;
        set_req(n, a, b, c);
        @(negedge clk);
        check({nm, "_ready"}, 64'(n == 0 ? req0_ready : req1_ready), 64'(1));
        @(posedge clk); #1;
        idle_reqs();
        @(negedge clk);
        check({nm, "_exec_ctrl"}, 64'(alu_ctrl), 64'(c));
        check({nm, "_exec_valid"}, 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check({nm, "_resp_valid"}, 64'(rsp_valid), 64'(1));
        check({nm, "_result"}, 64'(rsp_result), 64'(er));
        check({nm, "_zero"}, 64'(rsp_zero), 64'(ez));
        check({nm, "_id"}, 64'(rsp_id), 64'(n));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        int hs0, id0;
        int grants[$];
        logic [W-1:0] rres[$];
        logic rz[$];
        logic rid[$];

        reset = 1'b1;
        rsp_ready = 1'b1;
        req0_srca = '0; req0_srcb = '0; req0_ctrl = '0;
        req1_srca = '0; req1_srcb = '0; req1_ctrl = '0;
        idle_reqs();
        set_req(0, 32'd1, 32'd1, 3'b010);
        set_req(1, 32'd2, 32'd2, 3'b010);

        // Ready held low while reset is asserted, even with both requesters valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", 64'(req0_ready), 64'(0));
        check("rst_req1_ready", 64'(req1_ready), 64'(0));
        @(posedge clk); #1;
        idle_reqs();
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_rsp_valid",  64'(rsp_valid),  64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        check("rst_rsp_id",     64'(rsp_id),     64'(0));
        check("rst_alu_srca",   64'(alu_srca),   64'(0));
        check("rst_alu_ctrl",   64'(alu_ctrl),   64'(0));
        @(posedge clk); #1;

        // Single request: 5 + 7.
        run_op(0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, "add");

        // Contention: grants alternate 0,1,0 starting from reset.
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 32'd9, 32'd9, 3'b110);
        set_req(1, 32'd3, 32'd4, 3'b001);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                rres.push_back(rsp_result);
                rz.push_back(rsp_zero);
                rid.push_back(rsp_id);
            end
            @(posedge clk); #1;
        end
        idle_reqs();
        check("rr_grant_count", 64'(grants.size()), 64'(3));
        if (grants.size() >= 3) begin
            check("rr_grant0", 64'(grants[0]), 64'(0));
            check("rr_grant1", 64'(grants[1]), 64'(1));
            check("rr_grant2", 64'(grants[2]), 64'(0));
        end
        check("rr_resp_count", 64'(rres.size()), 64'(3));
        if (rres.size() >= 2) begin
            check("rr_sub_result", 64'(rres[0]), 64'(0));
            check("rr_sub_zero",   64'(rz[0]),   64'(1));
            check("rr_sub_id",     64'(rid[0]),  64'(0));
            check("rr_or_result",  64'(rres[1]), 64'(7));
            check("rr_or_zero",    64'(rz[1]),   64'(0));
            check("rr_or_id",      64'(rid[1]),  64'(1));
        end

        // Backpressure: 0xF0 & 0x3C held for five stalled cycles while req1 waits.
        rsp_ready = 1'b0;
        set_req(0, 32'hF0, 32'h3C, 3'b000);
        @(negedge clk);
        check("bp_ready0", 64'(req0_ready), 64'(1));
        @(posedge clk); #1;
        idle_reqs();
        set_req(1, 32'd5, 32'd3, 3'b111);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(2));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_valid",  64'(rsp_valid),  64'(1));
            check("bp_hold_result", 64'(rsp_result), 64'(32'h30));
            check("bp_hold_ready1", 64'(req1_ready), 64'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_take_ready1", 64'(req1_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_ready1", 64'(req1_ready), 64'(1));
        @(posedge clk); #1;
        idle_reqs();
        wait_valid(lat);
        check("bp_slt_result", 64'(rsp_result), 64'(0));
        check("bp_slt_zero",   64'(rsp_zero),   64'(1));
        check("bp_slt_id",     64'(rsp_id),     64'(1));
        @(posedge clk); #1;

        // Reset while in EXEC discards the req1 slt; req0 then wins contention.
        hs0 = n_hs;
        set_req(1, 32'd2, 32'd3, 3'b111);
        @(negedge clk);
        check("rx_ready1", 64'(req1_ready), 64'(1));
        @(posedge clk); #1;
        idle_reqs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rx_no_response", 64'(seen), 64'(0));
        check("rx_no_handshake", 64'(n_hs - hs0), 64'(0));
        @(posedge clk); #1;
        set_req(0, 32'd1, 32'd2, 3'b010);
        set_req(1, 32'd8, 32'd8, 3'b010);
        @(negedge clk);
        check("rx_contend_ready0", 64'(req0_ready), 64'(1));
        check("rx_contend_ready1", 64'(req1_ready), 64'(0));
        @(posedge clk); #1;
        idle_reqs();
        wait_valid(lat);
        check("rx_result", 64'(rsp_result), 64'(3));
        check("rx_id",     64'(rsp_id),     64'(0));
        @(posedge clk); #1;

        // Withdrawn request: req1 pulses valid only while a response is pending.
        hs0 = n_hs;
        id0 = n_id1;
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd1, 3'b010);
        @(posedge clk); #1;
        idle_reqs();
        wait_valid(lat);
        @(posedge clk); #1;
        set_req(1, 32'd6, 32'd6, 3'b010);
        @(negedge clk);
        check("wd_ready1", 64'(req1_ready), 64'(0));
        @(posedge clk); #1;
        idle_reqs();
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("wd_handshakes", 64'(n_hs - hs0), 64'(1));
        check("wd_no_id1",     64'(n_id1 - id0), 64'(0));

        // Shift and an undefined code passed through untouched.
        run_op(0, 32'd4, 32'd1, 3'b100, 32'd16, 1'b0, "sll");
        run_op(0, 32'd5, 32'd9, 3'b011, 32'd0,  1'b1, "undef");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1: synchronous, active-high reset.
REQ-004 Ports req0_valid, req1_valid  input  1 each: requester n presents an operation.
REQ-005 Ports req0_ready, req1_ready  output  1 each: block accepts requester n this cycle.
REQ-006 Ports req0_srca, req0_srcb, req1_srca, req1_srcb  input  WIDTH each: operands.
REQ-007 Ports req0_ctrl, req1_ctrl  input  3 each: ALU operation code, passed through unmodified.
REQ-008 Ports alu_srca, alu_srcb  output  WIDTH: operands driven to the shared combinational ALU.
REQ-009 Port alu_ctrl  output  3: operation code driven to the ALU.
REQ-010 Ports alu_result  input  WIDTH, alu_zero  input  1: ALU outputs, valid in the same cycle.
REQ-011 Port rsp_valid  output  1: response available.
REQ-012 Port rsp_ready  input  1: consumer takes the response.
REQ-013 Ports rsp_id  output  1, rsp_result  output  WIDTH, rsp_zero  output  1: originating requester, registered result, registered zero flag.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; the block holds at most one operation in flight.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, capture its srca/srcb/ctrl and grant id into internal registers, go to EXEC.
REQ-016 IDLE with no valid: stay IDLE, both ready low.
REQ-017 Arbitration: single valid wins; both valid -> the requester not granted last wins (round-robin); last-grant pointer updates only on acceptance.
REQ-018 At most one reqN_ready high in any cycle; both low outside IDLE.
REQ-019 alu_srca/alu_srcb/alu_ctrl always driven from the captured operand registers (no direct input-to-ALU path).
REQ-020 EXEC lasts exactly one cycle: at its closing edge capture alu_result into rsp_result, alu_zero into rsp_zero, grant id into rsp_id; go to RESP.
REQ-021 RESP: rsp_valid=1; rsp_id/rsp_result/rsp_zero held stable until rsp_ready sampled high; then go IDLE and drop rsp_valid next cycle.
REQ-022 Latency: accept at edge T -> rsp_valid high in cycle T+2; minimum 3 cycles between acceptances with rsp_ready tied high.
REQ-023 Requester may drop valid before ready without effect; no operation is recorded unless valid and ready coincide.
REQ-024 Invalid ctrl codes are passed through; result is whatever the ALU returns (0 for undefined codes).
REQ-025 rsp_valid never asserted in IDLE or EXEC.

Reset
REQ-026 reset high at a clock edge: state -> IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, operand and ctrl registers=0, last-grant pointer=1 (req0 wins the first contention).
REQ-027 Reset mid-operation (EXEC or RESP) discards the operation silently; no response is produced.
REQ-028 While reset is high both reqN_ready are low.

Verification
REQ-029 Single request: req0 add 5+7 (ctrl 010), rsp_ready=1 -> req0_ready at T, rsp_valid at T+2, rsp_result=12, rsp_zero=0, rsp_id=0.
REQ-030 Contention: both valid continuously after reset, req0 sub 9-9 (110), req1 or 3|4 (001) -> grants alternate 0,1,0; responses 0 (zero=1, id 0) then 7 (zero=0, id 1).
REQ-031 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_result stable, both reqN_ready low, new accept only after rsp_ready high plus one cycle.
REQ-032 Reset in EXEC after accepting req1 slt 2<3 -> no rsp_valid afterward; next simultaneous request grants req0.
REQ-033 Withdrawn request: req1_valid pulsed one cycle while FSM in RESP -> never accepted, no response with id 1.
REQ-034 Shift and invalid code: req0 ctrl 100, srca=4, srcb=1 -> result 16; ctrl passed as-is for undefined-code case -> result 0, zero=1.
